// File: rtl/fpu_pkg.sv
// Shared FP32 field widths, constants, operand classes and FSM states for the FPU units.
package fpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned QBITS    = 27;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned EXPS_W   = 10;
  localparam int unsigned REM_W    = MANT_W + 1;
  localparam int unsigned FLAGS_W  = 4;

  localparam logic [DATA_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [DATA_W-2:0] INF_MAG = 31'h7F800000;

  localparam int unsigned FLAG_INVALID = 3;
  localparam int unsigned FLAG_DIV0    = 2;
  localparam int unsigned FLAG_OVF     = 1;
  localparam int unsigned FLAG_UNF     = 0;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Denormals are flushed: any zero exponent classifies as zero.
  function automatic fp_class_e classify(input fp32_t x);
    if (x.exp == '0)      return ZERO;
    else if (x.exp == '1) return (x.frac == '0) ? INF : NAN;
    else                  return NORMAL;
  endfunction

endpackage

// File: rtl/fpu_div_if.sv
// Operand/result bus shared by the FPU units: request side from the issuer, result side from the unit.
interface fpu_div_if #(parameter int unsigned DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [3:0]            o_flags;

  modport master (output i_data_a, i_data_b, i_valid,
                  input  o_ready, o_data, o_valid, o_flags);
  modport slave  (input  i_data_a, i_data_b, i_valid,
                  output o_ready, o_data, o_valid, o_flags);
endinterface

// File: rtl/fpu_round_pack.sv
// Rounds a 27-bit quotient to nearest-even and packs an FP32 result, resolving special operand classes.
module fpu_round_pack
  import fpu_pkg::*;
(
  input  logic [QBITS-1:0]         q,
  input  logic                     rem_nz,
  input  logic                     sign,
  input  logic signed [EXPS_W-1:0] exp_in,
  input  fp_class_e                cls_a,
  input  fp_class_e                cls_b,
  output logic [DATA_W-1:0]        word,
  output logic [FLAGS_W-1:0]       flags
);

  logic [MANT_W-1:0]        mant;
  logic [MANT_W:0]          mant_r;
  logic [FRAC_W-1:0]        frac;
  logic                     rnd;
  logic                     stk;
  logic signed [EXPS_W-1:0] e;

  always_comb begin
    word   = '0;
    flags  = '0;
    mant   = '0;
    rnd    = 1'b0;
    stk    = 1'b0;
    e      = exp_in;
    mant_r = '0;
    frac   = '0;

    if (q[QBITS-1]) begin
      mant = q[QBITS-1:3];
      rnd  = q[2];
      stk  = q[1] | q[0] | rem_nz;
    end else begin
      mant = q[QBITS-2:2];
      rnd  = q[1];
      stk  = q[0] | rem_nz;
      e    = exp_in - 10'sd1;
    end

    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd & (stk | mant[0])};
    // Mantissa carry-out leaves 1.000..0, whose fraction is the zero upper slice.
    if (mant_r[MANT_W]) begin
      frac = mant_r[MANT_W-1:1];
      e    = e + 10'sd1;
    end else begin
      frac = mant_r[FRAC_W-1:0];
    end

    if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == INF) ||
        (cls_a == ZERO && cls_b == ZERO)) begin
      word                = QNAN;
      flags[FLAG_INVALID] = 1'b1;
    end else if (cls_a == INF) begin
      word = {sign, INF_MAG};
    end else if (cls_b == INF) begin
      word = {sign, 31'd0};
    end else if (cls_b == ZERO) begin
      word             = {sign, INF_MAG};
      flags[FLAG_DIV0] = 1'b1;
    end else if (cls_a == ZERO) begin
      word = {sign, 31'd0};
    end else if (e >= 10'sd255) begin
      word            = {sign, INF_MAG};
      flags[FLAG_OVF] = 1'b1;
    end else if (e <= 10'sd0) begin
      word            = {sign, 31'd0};
      flags[FLAG_UNF] = 1'b1;
    end else begin
      word = {sign, e[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fpu_div.sv
// Multi-cycle FP32 divider: restoring radix-2 mantissa division, one quotient bit per clock, then round/pack.
module fpu_div
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  fpu_div_if.slave  bus
);

  if (DATA_WIDTH != DATA_W) begin : g_width_check
    $error("fpu_div: only DATA_WIDTH=32 is supported");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [MANT_W-1:0]        mb_q, mb_d;
  logic [QBITS-1:0]         q_q, q_d;
  logic                     sign_q, sign_d;
  logic signed [EXPS_W-1:0] exp_q, exp_d;
  fp_class_e                cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [FLAGS_W-1:0]       flags_q, flags_d;

  fp32_t                    op_a, op_b;
  logic [MANT_W-1:0]        diff;
  logic                     qbit;
  logic [DATA_W-1:0]        rp_word;
  logic [FLAGS_W-1:0]       rp_flags;

  assign op_a = bus.i_data_a;
  assign op_b = bus.i_data_b;

  fpu_round_pack u_round_pack (
    .q      (q_q),
    .rem_nz (rem_q != '0),
    .sign   (sign_q),
    .exp_in (exp_q),
    .cls_a  (cls_a_q),
    .cls_b  (cls_b_q),
    .word   (rp_word),
    .flags  (rp_flags)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      q_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      cls_a_q <= ZERO;
      cls_b_q <= ZERO;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      q_q     <= q_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      cls_a_q <= cls_a_d;
      cls_b_q <= cls_b_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    q_d     = q_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    cls_a_d = cls_a_q;
    cls_b_d = cls_b_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    data_d  = data_q;
    flags_d = flags_q;
    diff    = '0;
    qbit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_valid && ready_q) begin
          sign_d  = op_a.sign ^ op_b.sign;
          exp_d   = $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp}) + 10'sd127;
          cls_a_d = classify(op_a);
          cls_b_d = classify(op_b);
          rem_d   = {2'b01, op_a.frac};
          mb_d    = {1'b1, op_b.frac};
          q_d     = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        // Partial remainder stays below 2*mb, so the difference always fits the mantissa width.
        if (rem_q >= {1'b0, mb_q}) begin
          qbit = 1'b1;
          diff = MANT_W'(rem_q - {1'b0, mb_q});
        end else begin
          diff = rem_q[MANT_W-1:0];
        end
        rem_d = {diff, 1'b0};
        q_d   = {q_q[QBITS-2:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(QBITS - 1)) state_d = NORM;
      end
      NORM: begin
        data_d  = rp_word;
        flags_d = rp_flags;
        valid_d = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_flags = flags_q;

endmodule

// File: doc/fpu_div.md
Name: fpu_div

Overview:
- Multi-cycle IEEE-754 single-precision divider (o_data = a / b).
- Inverse-direction companion to the combinational add/mul FPU; shares its operand/result bus format.
- Radix-2 restoring mantissa division, one quotient bit per clock, then a single round/pack cycle.
- Fixed-latency valid/ready handshake; sits beside the add/mul unit behind the same issue logic.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported (elaborate-time check).

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_data_a  input  32  dividend, FP32
i_data_b  input  32  divisor, FP32
i_valid  input  1  request; accepted on an edge where i_valid && o_ready
o_ready  output  1  high when IDLE
o_data  output  32  quotient, FP32; held until next result
o_valid  output  1  one-cycle result pulse
o_flags  output  4  {invalid, div_by_zero, overflow, underflow}; valid with o_valid, held after

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_data=0, o_flags=0, counter=0. Reset mid-operation aborts the operation; no o_valid is produced for it.
- States:
  - IDLE: on accept, latch signs, exponents and mantissas; classify operands; r=ma; cnt=0; go to DIV.
  - DIV: 27 cycles. Each cycle: if r>=mb, q bit=1 and r-=mb, else q bit=0; r<<=1; cnt++. Leave after cnt==26.
  - NORM: one cycle. Round/pack, register o_data/o_flags, pulse o_valid, return to IDLE.
- Latency: acceptance edge E, o_valid high in the cycle after edge E+28, for all inputs including special cases (the DIV cycles still run).
- Handshake:
  - o_ready is low from DIV through NORM; i_valid while busy is ignored, not queued.
  - A new request may be accepted in the same cycle o_valid is high (back-to-back interval 29 cycles).
- Operand classes:
  - exp==0 → zero (denormals flushed, fraction ignored).
  - exp==255, frac==0 → inf.
  - exp==255, frac!=0 → NaN.
  - Otherwise normal, mantissa {1,frac}.
- Special-case priority (sign = sa^sb unless NaN):
  1. Any NaN, inf/inf, or 0/0 → 0x7FC00000, invalid=1.
  2. inf/x → signed inf.
  3. x/inf → signed zero.
  4. x/0 → signed inf, div_by_zero=1.
  5. 0/x → signed zero.
- Arithmetic (normal/normal):
  - q[26:0], q[26] has weight 1.
  - Biased exponent, 10-bit signed: e = ea - eb + 127.
  - If q[26]=1: M=q[26:3], R=q[2], S=q[1]|q[0]|(r!=0).
  - Else: M=q[25:2], R=q[1], S=q[0]|(r!=0), e=e-1.
  - Round to nearest even: increment M if R && (S || M[0]). If M overflows to 2^24, set M=0x800000 and e=e+1.
  - e>=255 → signed inf, overflow=1.
  - e<=0 → signed zero, underflow=1 (no denormal output).
  - Otherwise pack {s, e[7:0], M[22:0]}.
- o_flags bits not named above are 0 for that result.

Decomposition:
- Package fpu_pkg:
  - FP32 field widths: EXP_W=8, FRAC_W=23, MANT_W=24.
  - EXP_BIAS=127, QBITS=27.
  - Constants QNAN=32'h7FC00000, INF_MAG=31'h7F800000.
  - Operand-class enum {ZERO, NORMAL, INF, NAN}.
  - State enum {IDLE, DIV, NORM}.
  - Flag bit indices.
- One combinational sub-module, fpu_round_pack: takes q, remainder-nonzero, sign, 10-bit exponent and class info; returns packed word and flags. Instanced in NORM, reusable by add/mul later.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) → o_data 0x40400000, flags 0, o_valid exactly 28 edges after accept, one cycle wide.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (round-up path). Then 0xC0F00000 / 0x40200000 → 0xC0400000.
- Specials: 0x3F800000/0 → 0x7F800000, flags 4'b0100; 0/0 → 0x7FC00000, 4'b1000; 0x7FC00001/any → 0x7FC00000, 4'b1000; 0xFF800000/0x40000000 → 0xFF800000. All at the same 28-cycle latency.
- Range: 0x7F000000 / 0x3E800000 → 0x7F800000, 4'b0010. 0x00800000 / 0x40000000 → 0x00000000, 4'b0001. Denormal dividend 0x00000001 / 0x3F800000 → 0x00000000, flags 0.
- Handshake: hold i_valid with new operands during DIV → o_ready=0, ignored, first result unchanged. Issue a second op in the o_valid cycle → accepted, second o_valid 29 cycles after the first.
- Reset: assert i_rst at DIV cycle 10 → next cycle o_ready=1, o_valid=0, o_data=0; no stale o_valid; the next op returns the correct result.
